// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, segment table and hex encode helper
// for the multiplexed seven-segment display stage.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high gfedcba patterns, entry F first down to entry 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] v
  );
    return SEG_TABLE[v];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: 4-bit hex value to active-high segments.
// Ports: val_i hex digit, blank_i forces dark, seg_o bit0=a..bit6=g.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_OFF : hex_to_seg(val_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered multiplexed 7-seg scanner.
// Ports: clk, reset (async high), en, load, digits_in, dp_in in;
// seg_out, dp_out, an_out, digit_idx, frame_done out (registered).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int BLANK_CYCLES    = 8,
  parameter int SEG_ACTIVE_LOW  = 0,
  parameter int LEAD_ZERO_BLANK = 1,
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int PRE_W =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_LAST =
    PRE_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam state_t SLOT_START =
    (BLANK_CYCLES == 0) ? SHOW : BLANK;
  localparam logic INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_DARK =
    INV ? ~SEG_OFF : SEG_OFF;

  state_t                       state_q;
  logic [PRE_W-1:0]             pre_q;
  logic [IDX_W-1:0]             idx_q;
  logic [NUM_DIGITS-1:0][3:0]   pend_dig_q;
  logic [NUM_DIGITS-1:0][3:0]   act_dig_q;
  logic [NUM_DIGITS-1:0]        pend_dp_q;
  logic [NUM_DIGITS-1:0]        act_dp_q;
  logic                         fd_q;
  logic [6:0]                   seg_q;
  logic                         dp_q;
  logic [NUM_DIGITS-1:0]        an_q;

  logic                         slot_end;
  logic                         wrap;
  logic                         copy_act;
  logic [NUM_DIGITS-1:0]        lz_blank;
  logic                         lz_run;
  logic [6:0]                   dec_seg;
  logic                         show;
  logic [NUM_DIGITS-1:0]        an_d;
  logic [6:0]                   seg_d;
  logic                         dp_d;

  assign slot_end = (pre_q == PRE_LAST);
  assign wrap     = (state_q != IDLE) && slot_end
                 && (idx_q == IDX_LAST);
  // Active buffer refreshes only at frame edges or on wake-up.
  assign copy_act = en && ((state_q == IDLE) || wrap);

  // Digit k blanks when it and every higher digit are zero.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run && (act_dig_q[k] == 4'h0);
      lz_blank[k] = (LEAD_ZERO_BLANK != 0) && lz_run;
    end
  end

  seg7_hex_decoder u_dec (
    .val_i   (act_dig_q[idx_q]),
    .blank_i (lz_blank[idx_q]),
    .seg_o   (dec_seg)
  );

  assign show  = (state_q == SHOW);
  assign an_d  = show ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign seg_d = show ? dec_seg : SEG_OFF;
  assign dp_d  = show && act_dp_q[idx_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      act_dig_q  <= '0;
      pend_dp_q  <= '0;
      act_dp_q   <= '0;
      fd_q       <= 1'b0;
      seg_q      <= SEG_DARK;
      dp_q       <= INV;
      an_q       <= '0;
    end else begin
      fd_q  <= 1'b0;
      an_q  <= an_d;
      seg_q <= INV ? ~seg_d : seg_d;
      dp_q  <= INV ? ~dp_d : dp_d;
      if (load) begin
        pend_dig_q <= digits_in;
        pend_dp_q  <= dp_in;
      end
      if (copy_act) begin
        act_dig_q <= load ? digits_in : pend_dig_q;
        act_dp_q  <= load ? dp_in : pend_dp_q;
      end
      if (!en) begin
        state_q <= IDLE;
        pre_q   <= '0;
        idx_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= SLOT_START;
            pre_q   <= '0;
            idx_q   <= '0;
          end
          BLANK, SHOW: begin
            if (slot_end) begin
              state_q <= SLOT_START;
              pre_q   <= '0;
              fd_q    <= (idx_q == IDX_LAST);
              idx_q   <= (idx_q == IDX_LAST) ?
                         '0 : idx_q + 1'b1;
            end else begin
              pre_q <= pre_q + 1'b1;
              if (state_q == BLANK
                  && pre_q == BLANK_LAST)
                state_q <= SHOW;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of the scan driver,
// one active-high and one active-low instance.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset, en, load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  logic        rst_lo, en_lo, load_lo;
  logic [15:0] digits_lo;
  logic [3:0]  dpi_lo;
  logic [6:0]  seg_lo;
  logic        dp_lo;
  logic [3:0]  an_lo;
  logic [1:0]  idx_lo;
  logic        fd_lo;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(0), .LEAD_ZERO_BLANK(1)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .digits_in(digits_in), .dp_in(dp_in),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .LEAD_ZERO_BLANK(1)
  ) u_low (
    .clk(clk), .reset(rst_lo), .en(en_lo), .load(load_lo),
    .digits_in(digits_lo), .dp_in(dpi_lo),
    .seg_out(seg_lo), .dp_out(dp_lo), .an_out(an_lo),
    .digit_idx(idx_lo), .frame_done(fd_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string t);
    int n;
    n = 0;
    tick();
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(t, 32'(frame_done), 1);
  endtask

  // Starts on the frame_done sample; checks each SHOW slot.
  task automatic show_frame(input logic [6:0] s0,
                            input logic [6:0] s1,
                            input logic [6:0] s2,
                            input logic [6:0] s3,
                            input logic [3:0] dp,
                            input string t);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_an%0d", t, k),
          32'(an_out), 32'(4'b0001 << k));
      chk($sformatf("%s_seg%0d", t, k),
          32'(seg_out), 32'(s[k]));
      chk($sformatf("%s_dp%0d", t, k),
          32'(dp_out), 32'(dp[k]));
      chk($sformatf("%s_idx%0d", t, k),
          32'(digit_idx), k);
      if (k < 3) repeat (4) tick();
    end
  endtask

  initial begin
    int lit, fds;
    reset = 1'b1; en = 1'b1; load = 1'b0;
    digits_in = '0; dp_in = '0;
    rst_lo = 1'b1; en_lo = 1'b0; load_lo = 1'b0;
    digits_lo = '0; dpi_lo = '0;
    repeat (2) tick();

    // reset state
    chk("rst_an", 32'(an_out), 0);
    chk("rst_seg", 32'(seg_out), 0);
    chk("rst_dp", 32'(dp_out), 0);
    chk("rst_idx", 32'(digit_idx), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_lo_seg", 32'(seg_lo), 'h7F);
    chk("rst_lo_dp", 32'(dp_lo), 1);
    chk("rst_lo_an", 32'(an_lo), 0);

    // first slot latency after release
    reset = 1'b0;
    tick();
    chk("t1_e1_an", 32'(an_out), 0);
    tick();
    chk("t1_e2_an", 32'(an_out), 0);
    tick();
    chk("t1_e3_an", 32'(an_out), 1);
    chk("t1_e3_seg", 32'(seg_out), 'h3F);

    // frame period and anode duty
    wait_frame("t1_fd0");
    lit = 0; fds = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (an_out != 4'b0) lit++;
      if (frame_done && i < 16) fds++;
    end
    chk("t1_period", 32'(frame_done), 1);
    chk("t1_early_fd", fds, 0);
    chk("t1_duty", lit, 12);
    show_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, "t1");

    // load mid-frame, visible only from next frame
    wait_frame("t2_fd");
    tick();
    load = 1'b1; digits_in = 16'h12A7;
    tick();
    load = 1'b0;
    chk("t2_old0", 32'(seg_out), 'h3F);
    repeat (4) tick();
    chk("t2_old1_an", 32'(an_out), 'b0010);
    chk("t2_old1_seg", 32'(seg_out), 'h00);
    wait_frame("t2_fd2");
    show_frame(7'h07, 7'h77, 7'h5B, 7'h06, 4'b0000, "t2");

    // two loads in one frame: last wins
    wait_frame("t3_fd");
    tick();
    load = 1'b1; digits_in = 16'h0050;
    tick();
    load = 1'b0;
    repeat (3) tick();
    load = 1'b1; digits_in = 16'h0003;
    tick();
    load = 1'b0;
    chk("t3_hold_an", 32'(an_out), 'b0010);
    chk("t3_hold_seg", 32'(seg_out), 'h77);
    wait_frame("t3_fd2");
    show_frame(7'h4F, 7'h00, 7'h00, 7'h00, 4'b0000, "t3");

    // load on the wrap cycle lands in that frame
    tick();
    load = 1'b1; digits_in = 16'h0A03; dp_in = 4'b1000;
    tick();
    load = 1'b0;
    chk("t4_fd", 32'(frame_done), 1);
    show_frame(7'h4F, 7'h3F, 7'h77, 7'h00, 4'b1000, "t4");

    // en drop at prescaler 2 of slot 2
    wait_frame("t5_fd");
    repeat (10) tick();
    chk("t5_pre_an", 32'(an_out), 'b0100);
    en = 1'b0;
    tick();
    chk("t5_idx", 32'(digit_idx), 0);
    tick();
    chk("t5_dark_an", 32'(an_out), 0);
    chk("t5_dark_seg", 32'(seg_out), 0);
    chk("t5_dark_dp", 32'(dp_out), 0);
    lit = 0; fds = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (an_out != 4'b0) lit++;
      if (frame_done) fds++;
    end
    chk("t5_idle_lit", lit, 0);
    chk("t5_idle_fd", fds, 0);
    en = 1'b1;
    tick();
    chk("t5_re1_idx", 32'(digit_idx), 0);
    chk("t5_re1_an", 32'(an_out), 0);
    tick();
    chk("t5_re2_an", 32'(an_out), 0);
    tick();
    chk("t5_re3_an", 32'(an_out), 1);
    chk("t5_re3_seg", 32'(seg_out), 'h4F);

    // active-low instance, load while idle
    rst_lo = 1'b0;
    tick();
    load_lo = 1'b1; digits_lo = 16'h0008; dpi_lo = 4'b0001;
    tick();
    load_lo = 1'b0;
    chk("t6_idle_seg", 32'(seg_lo), 'h7F);
    chk("t6_idle_dp", 32'(dp_lo), 1);
    en_lo = 1'b1;
    tick();
    chk("t6_e1_seg", 32'(seg_lo), 'h7F);
    chk("t6_e1_an", 32'(an_lo), 0);
    tick();
    tick();
    chk("t6_show_an", 32'(an_lo), 1);
    chk("t6_show_seg", 32'(seg_lo), 'h00);
    chk("t6_show_dp", 32'(dp_lo), 0);
    repeat (4) tick();
    chk("t6_s1_an", 32'(an_lo), 'b0010);
    chk("t6_s1_seg", 32'(seg_lo), 'h7F);
    chk("t6_s1_dp", 32'(dp_lo), 1);
    #1 rst_lo = 1'b1;
    #1;
    chk("t6_async_an", 32'(an_lo), 0);
    chk("t6_async_seg", 32'(seg_lo), 'h7F);
    chk("t6_async_dp", 32'(dp_lo), 1);
    tick();
    rst_lo = 1'b0;
    repeat (3) tick();
    chk("t6_clr_an", 32'(an_lo), 1);
    chk("t6_clr_seg", 32'(seg_lo), 'h40);
    chk("t6_clr_dp", 32'(dp_lo), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
